// File: rtl/sw_seq_loader.sv
// Byte-stream deframer feeding the Smith-Waterman core: assembles two lengths and
// two 2-bit-packed base vectors from a fixed-size frame and presents them as one job.
module sw_seq_loader #(
  parameter int REF_MAX_LENGTH  = 128,
  parameter int READ_MAX_LENGTH = 128,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   i_byte,
  input  logic                         i_byte_valid,
  output logic                         o_byte_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [2*REF_MAX_LENGTH-1:0]  o_sequence_ref,
  output logic [2*READ_MAX_LENGTH-1:0] o_sequence_read,
  output logic [LEN_WIDTH-1:0]         o_seq_ref_length,
  output logic [LEN_WIDTH-1:0]         o_seq_read_length,
  output logic                         o_len_error,
  output logic [2:0]                   dbg_state
);

  localparam int REF_BYTES   = REF_MAX_LENGTH / 4;
  localparam int READ_BYTES  = READ_MAX_LENGTH / 4;
  localparam int FRAME_BYTES = 2 + REF_BYTES + READ_BYTES;
  localparam int CNT_W       = $clog2(FRAME_BYTES);

  typedef enum logic [2:0] {
    S_LEN_REF  = 3'd0,
    S_LEN_READ = 3'd1,
    S_REF      = 3'd2,
    S_READ     = 3'd3,
    S_PRESENT  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             xfer;
  logic             ref_last;
  logic             read_last;
  logic             len_ok;

  // Byte stream handshake: a byte moves only on a cycle where i_byte_valid and
  // o_byte_ready are both high; o_byte_ready depends on state alone, never on i_byte_valid.
  // Job handshake: the job is taken on the cycle where o_valid and i_ready are both high.
  assign o_byte_ready = (state != S_PRESENT);
  assign o_valid      = (state == S_PRESENT);
  assign xfer         = i_byte_valid && o_byte_ready;
  assign dbg_state    = state;

  assign ref_last  = (cnt == CNT_W'(REF_BYTES - 1));
  assign read_last = (cnt == CNT_W'(READ_BYTES - 1));

  // Each field is judged on its own: zero or above its maximum rejects the frame.
  assign len_ok = (o_seq_ref_length != '0)
               && (o_seq_ref_length <= LEN_WIDTH'(REF_MAX_LENGTH))
               && (o_seq_read_length != '0)
               && (o_seq_read_length <= LEN_WIDTH'(READ_MAX_LENGTH));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_LEN_REF;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_REF:  if (xfer) state_nxt = S_LEN_READ;
      S_LEN_READ: if (xfer) state_nxt = S_REF;
      S_REF:      if (xfer && ref_last) state_nxt = S_READ;
      S_READ:     if (xfer && read_last) state_nxt = len_ok ? S_PRESENT : S_LEN_REF;
      S_PRESENT:  if (i_ready) state_nxt = S_LEN_REF;
      default:    state_nxt = S_LEN_REF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt               <= '0;
      o_sequence_ref    <= '0;
      o_sequence_read   <= '0;
      o_seq_ref_length  <= '0;
      o_seq_read_length <= '0;
      o_len_error       <= 1'b0;
    end else if (xfer) begin
      case (state)
        S_LEN_REF: begin
          o_seq_ref_length <= LEN_WIDTH'(i_byte);
          o_len_error      <= 1'b0;
        end
        S_LEN_READ: begin
          o_seq_read_length <= LEN_WIDTH'(i_byte);
          cnt               <= '0;
        end
        S_REF: begin
          o_sequence_ref <= {o_sequence_ref[2*REF_MAX_LENGTH-9:0], i_byte};
          cnt            <= ref_last ? '0 : cnt + CNT_W'(1);
        end
        S_READ: begin
          o_sequence_read <= {o_sequence_read[2*READ_MAX_LENGTH-9:0], i_byte};
          cnt             <= read_last ? '0 : cnt + CNT_W'(1);
          // Rejection depends only on the latched lengths, never on base data.
          if (read_last && !len_ok) o_len_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Directed bench for sw_seq_loader: a table of whole frames with expected job
// outputs, followed by hand-written reset sequences.
module tb_sw_seq_loader;

  localparam int REF_MAX  = 128;
  localparam int READ_MAX = 128;
  localparam int LW       = 8;
  localparam int RB       = REF_MAX / 4;
  localparam int DB       = READ_MAX / 4;
  localparam int F        = 2 + RB + DB;

  logic                  clk;
  logic                  rst;
  logic [7:0]            i_byte;
  logic                  i_byte_valid;
  logic                  o_byte_ready;
  logic                  o_valid;
  logic                  i_ready;
  logic [2*REF_MAX-1:0]  o_sequence_ref;
  logic [2*READ_MAX-1:0] o_sequence_read;
  logic [LW-1:0]         o_seq_ref_length;
  logic [LW-1:0]         o_seq_read_length;
  logic                  o_len_error;
  logic [2:0]            dbg_state;

  sw_seq_loader #(.REF_MAX_LENGTH(REF_MAX), .READ_MAX_LENGTH(READ_MAX), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_sequence_ref(o_sequence_ref), .o_sequence_read(o_sequence_read),
    .o_seq_ref_length(o_seq_ref_length), .o_seq_read_length(o_seq_read_length),
    .o_len_error(o_len_error), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;

  always @(posedge clk) if (o_valid) valid_cycles++;

  typedef struct {
    logic [7:0] rl, dl;
    logic [7:0] r0, r1, rr;
    logic [7:0] d0, d1, dr;
    bit         gaps;
    int         hold;
    bit         exp_valid;
    bit         exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] build_vec(input logic [7:0] b0, b1, brest);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++)
      v[255 - 8*i -: 8] = (i == 0) ? b0 : (i == 1) ? b1 : brest;
    return v;
  endfunction

  function automatic logic [7:0] frame_byte(input int i, input vec_t v);
    int k;
    if (i == 0) return v.rl;
    if (i == 1) return v.dl;
    if (i < 2 + RB) begin
      k = i - 2;
      return (k == 0) ? v.r0 : (k == 1) ? v.r1 : v.rr;
    end
    k = i - 2 - RB;
    return (k == 0) ? v.d0 : (k == 1) ? v.d1 : v.dr;
  endfunction

  // Driver: present one byte from the falling edge and hold until a rising edge takes it.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_byte       = 8'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    i_byte       = b;
    i_byte_valid = 1'b1;
    guard = 0;
    while (!o_byte_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_fail++;
      $display("FAIL byte_ready_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(frame_byte(i, v), v.gaps);
      if (i == 0) check("err_clear_on_byte0", o_len_error, 0);
    end
  endtask

  task automatic check_job(input vec_t v);
    check("ref_vec",  o_sequence_ref,  build_vec(v.r0, v.r1, v.rr));
    check("read_vec", o_sequence_read, build_vec(v.d0, v.d1, v.dr));
    check("ref_len",  o_seq_ref_length,  v.rl);
    check("read_len", o_seq_read_length, v.dl);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},    o_valid, 0);
    check({tag, "_err"},      o_len_error, 0);
    check({tag, "_ref_vec"},  o_sequence_ref, 0);
    check({tag, "_read_vec"}, o_sequence_read, 0);
    check({tag, "_ref_len"},  o_seq_ref_length, 0);
    check({tag, "_read_len"}, o_seq_read_length, 0);
    check({tag, "_ready"},    o_byte_ready, 1);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    i_byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int v0;
    v0 = valid_cycles;
    send_frame(v, F);
    @(negedge clk);
    i_byte_valid = 1'b0;
    check("no_early_valid", valid_cycles - v0, 0);
    check("valid", o_valid, v.exp_valid);
    check("len_error", o_len_error, v.exp_err);
    if (v.exp_valid) begin
      check("ready_in_present", o_byte_ready, 0);
      check_job(v);
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        check("hold_valid", o_valid, 1);
        check("hold_ready", o_byte_ready, 0);
        check_job(v);
      end
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check("accept_valid", o_valid, 0);
      check("accept_ready", o_byte_ready, 1);
      check("accept_state", dbg_state, 0);
    end else begin
      check("reject_ready", o_byte_ready, 1);
      check("reject_state", dbg_state, 0);
      i_ready = 1'b1;
      repeat (3) @(negedge clk);
      i_ready = 1'b0;
      check("reject_no_valid", valid_cycles - v0, 0);
      check("reject_err_sticky", o_len_error, 1);
    end
  endtask

  vec_t hv;

  initial begin
    rst          = 1'b0;
    i_byte       = 8'h00;
    i_byte_valid = 1'b0;
    i_ready      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_zero("reset");
    check("reset_state", dbg_state, 0);

    //          rl      dl      r0     r1     rr     d0     d1     dr    gaps hold valid err
    vecs[0] = '{8'd128, 8'd128, 8'h1B, 8'h1B, 8'h1B, 8'hE4, 8'hE4, 8'hE4, 1'b0, 0,  1'b1, 1'b0};
    vecs[1] = '{8'd5,   8'd3,   8'h00, 8'h40, 8'h00, 8'hFC, 8'h00, 8'h00, 1'b0, 0,  1'b1, 1'b0};
    vecs[2] = '{8'd128, 8'd128, 8'h5A, 8'hC3, 8'h96, 8'h3C, 8'h81, 8'h7E, 1'b0, 10, 1'b1, 1'b0};
    vecs[3] = '{8'd0,   8'd10,  8'h1B, 8'h1B, 8'h1B, 8'hE4, 8'hE4, 8'hE4, 1'b0, 0,  1'b0, 1'b1};
    vecs[4] = '{8'd10,  8'd200, 8'h1B, 8'h1B, 8'h1B, 8'hE4, 8'hE4, 8'hE4, 1'b0, 0,  1'b0, 1'b1};
    vecs[5] = '{8'd10,  8'd10,  8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0, 0,  1'b1, 1'b0};
    vecs[6] = '{8'd128, 8'd128, 8'h1B, 8'h1B, 8'h1B, 8'hE4, 8'hE4, 8'hE4, 1'b1, 0,  1'b1, 1'b0};
    vecs[7] = '{8'd128, 8'd129, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 0,  1'b0, 1'b1};
    vecs[8] = '{8'd1,   8'd1,   8'hC0, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 1'b1, 2,  1'b1, 1'b0};

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Error flag set, then a reset while idle must clear it.
    run_vec(vecs[3]);
    pulse_reset();
    check("reset_clears_err", o_len_error, 0);

    // Reset after 40 bytes of a frame discards it; a fresh frame then works.
    hv = '{8'd7, 8'd9, 8'hAA, 8'hAA, 8'hAA, 8'h55, 8'h55, 8'h55, 1'b0, 0, 1'b1, 1'b0};
    send_frame(hv, 40);
    pulse_reset();
    check_zero("midframe_reset");
    hv = '{8'd12, 8'd6, 8'h33, 8'h0F, 8'h33, 8'hCC, 8'hF0, 8'hCC, 1'b0, 1, 1'b1, 1'b0};
    run_vec(hv);

    // Reset while a job is being presented drops it.
    hv = '{8'd4, 8'd4, 8'h1B, 8'h00, 8'h00, 8'hE4, 8'h00, 8'h00, 1'b0, 0, 1'b1, 1'b0};
    send_frame(hv, F);
    @(negedge clk);
    i_byte_valid = 1'b0;
    check("present_before_reset", o_valid, 1);
    pulse_reset();
    check_zero("present_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_seq_loader.md
Name: sw_seq_loader

Overview:
Byte-stream deframer between the UART receive path of the SW host wrapper and the Smith-Waterman core. It takes one fixed-size input frame per alignment job, byte by byte, over a valid/ready stream. Each frame holds two lengths and two 2-bit-packed base sequences. The block assembles the full reference and read vectors plus their lengths and presents them to the core with a valid/ready handshake. It rejects frames whose lengths are out of range.

Parameters:
REF_MAX_LENGTH, 128, max reference bases; must be a multiple of 4
READ_MAX_LENGTH, 128, max read bases; must be a multiple of 4
LEN_WIDTH, 8, width of the length fields; must hold the value MAX_LENGTH

Ports:
clk  in  1  single clock; all logic on its rising edge
rst  in  1  synchronous, active-low reset
i_byte  in  8  incoming frame byte
i_byte_valid  in  1  i_byte is valid this cycle
o_byte_ready  out  1  block accepts a byte this cycle
o_valid  out  1  assembled job available for the core
i_ready  in  1  core accepts the job
o_sequence_ref  out  2*REF_MAX_LENGTH  packed reference; base 0 at the MSBs
o_sequence_read  out  2*READ_MAX_LENGTH  packed read; base 0 at the MSBs
o_seq_ref_length  out  LEN_WIDTH  reference length in bases
o_seq_read_length  out  LEN_WIDTH  read length in bases
o_len_error  out  1  last frame was rejected for a bad length

Behaviour:
- Frame format, fixed size F = 2 + REF_MAX_LENGTH/4 + READ_MAX_LENGTH/4 bytes (66 at defaults):
  - byte 0: ref length
  - byte 1: read length
  - next REF_MAX_LENGTH/4 bytes: reference bases
  - next READ_MAX_LENGTH/4 bytes: read bases
- Packing: 4 bases per byte, bits [7:6] hold the first base. Encoding A=0, C=1, G=2, T=3.
- Bases beyond the stated length are transmitted as padding and stored unchanged. The core ignores them.
- Byte transfer: occurs only on a cycle where i_byte_valid and o_byte_ready are both 1.
  - o_byte_ready is a registered-state decode: 1 in every receive state, 0 in S_PRESENT.
  - Gaps in i_byte_valid stall the FSM with no state change.
- Sequence assembly: each accepted sequence byte shifts the target vector left by 8 and loads the byte into the low 8 bits. After the last byte, the first byte therefore sits at the MSBs.
- A byte counter, 7 bits at defaults, counts bytes within the current section and is cleared on each section change.
- FSM states:
  - S_LEN_REF: on transfer, latch ref length, go to S_LEN_READ.
  - S_LEN_READ: on transfer, latch read length, clear the counter, go to S_REF.
  - S_REF: shift bytes into the reference vector. On transfer of byte REF_MAX_LENGTH/4-1, clear the counter and go to S_READ.
  - S_READ: shift bytes into the read vector. On transfer of the last byte:
    - if both lengths are valid (1..MAX), set o_valid=1 and go to S_PRESENT;
    - otherwise set o_len_error=1 and go to S_LEN_REF, with o_valid never asserted.
  - S_PRESENT: hold o_valid=1 and all data outputs stable. On the cycle with i_ready=1, the handshake completes; the next cycle has o_valid=0, state S_LEN_REF, o_byte_ready=1.
- o_len_error:
  - cleared on the transfer of byte 0 of the next frame;
  - otherwise sticky;
  - must not depend on the read/ref byte data.
- Length check: 0 or a value greater than the corresponding MAX is invalid, judged per field. An invalid frame is still consumed in full (F bytes) to keep framing aligned.
- The output vectors and lengths are the internal shift registers themselves. They are only meaningful while o_valid=1, and change freely in receive states.
- i_ready while o_valid=0 is ignored.
- Reset (rst=0 at a clock edge), including mid-frame or mid-present: the next cycle state is S_LEN_REF and all of the following are 0:
  - o_valid
  - o_len_error
  - both vectors
  - both lengths
  - the counter

  o_byte_ready=1 from the first cycle after reset release. A partially received frame is discarded.
- Latency: o_valid rises on the cycle after the final frame byte is transferred.
- Throughput: one byte per cycle. The minimum gap between jobs is F transfer cycles plus 1 present cycle.

Test Plan:
- Full frame, lengths 128/128, ref all 0x1B (ACGT repeating), read all 0xE4 -> after 66 transfers, o_valid=1 next cycle; o_sequence_ref = 0x1B repeated 32 times; o_sequence_read = 0xE4 repeated 32 times; lengths 128/128; o_len_error=0.
- Short lengths 5/3, ref bytes 0x00,0x40 then 0x00 x30, read bytes 0xFC then 0x00 x31 -> o_seq_ref_length=5, o_seq_read_length=3; o_sequence_ref[255:248]=0x00 and [247:240]=0x40; o_sequence_read[255:248]=0xFC.
- Back-pressure: hold i_ready=0 for 10 cycles after o_valid -> o_valid and data stable for all 10 cycles, o_byte_ready=0 throughout; assert i_ready -> o_valid=0 and o_byte_ready=1 next cycle.
- Bad lengths: frame with ref length 0, then frame with read length 200 -> each frame consumed in 66 transfers, o_valid never rises, o_len_error=1 after each. A following valid 10/10 frame clears o_len_error on its byte 0 and produces o_valid.
- Random i_byte_valid gaps (~50% duty) over a 128/128 frame -> identical outputs to the gap-free case.
- Reset pulse after byte 40 of a frame, then a fresh valid frame -> after reset all outputs are 0. The fresh frame's byte 0 is taken as ref length and the job completes correctly.
